// File: rtl/lfa_arb_pkg.sv
// Shared types and helpers for the round-robin LFA_16b arbiter.
// Width constants, output-stage state enum, rotated-priority grant function.
package lfa_arb_pkg;

  localparam int DATA_W  = 16;
  localparam int SUM_W   = 17;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } ost_e;

  // One-hot grant: first set bit of req scanning from ptr, wrapping mod n.
  function automatic logic [MAX_REQ-1:0] rr_grant(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] g;
    logic [2:0]         j;
    logic               found;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        j = 3'((ptr + k) % n);
        if (!found && req[j]) begin
          g[j]  = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/LFA_16b.sv
// Exact 16b + 16b -> 17b adder; approximate variants share these ports.
// Ports: in0, in1 operands; out0 = in0 + in1 with carry-out in bit 16.
module LFA_16b (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic [16:0] out0
);

  assign out0 = {1'b0, in0} + {1'b0, in1};

endmodule

// File: rtl/lfa16_rr_pick.sv
// Combinational round-robin picker over NREQ request lines.
// Ports: req, ptr in; gnt (one-hot), vld, idx out.
module lfa16_rr_pick
  import lfa_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic            vld,
  output logic [ID_W-1:0] idx
);

  logic [MAX_REQ-1:0] req8;
  logic [MAX_REQ-1:0] g8;
  logic               unused_hi;

  always_comb begin
    req8            = '0;
    req8[NREQ-1:0]  = req;
    g8              = rr_grant(req8, 32'(ptr), NREQ);
    gnt             = g8[NREQ-1:0];
  end

  assign unused_hi = ^g8;
  assign vld       = |gnt;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/lfa16_rr_arbiter.sv
// Round-robin share of one LFA_16b among NREQ valid/ready requesters.
// Ports: clk, rst_n (sync, low); req_valid/ready/a/b per requester;
// rsp_valid/ready/sum/id one-deep output stage.
// LFA_ARB_STATS_EN adds stat_clr in, stat_grants out (16b sat counters).
module lfa16_rr_arbiter
  import lfa_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SUM_W-1:0]     rsp_sum,
  output logic [ID_W-1:0]      rsp_id
`ifdef LFA_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [16*NREQ-1:0]   stat_grants
`endif
);

  ost_e                state_q;
  ost_e                state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     ptr_nxt;
  logic [NREQ-1:0]     pick_gnt;
  logic                pick_vld;
  logic [ID_W-1:0]     pick_idx;
  logic                can_accept;
  logic                grant;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_q;
  logic [ID_W-1:0]     id_q;

  lfa16_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // rsp_ready reaches req_ready combinationally: a draining result
  // frees the stage for a replacement in the same cycle.
  assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
  assign req_ready  = (rst_n && can_accept) ? pick_gnt : '0;
  assign grant      = rst_n & can_accept & pick_vld;

  assign a_sel = req_a[pick_idx*DATA_W +: DATA_W];
  assign b_sel = req_b[pick_idx*DATA_W +: DATA_W];

  LFA_16b u_add (
    .in0  (a_sel),
    .in1  (b_sel),
    .out0 (sum)
  );

  assign ptr_nxt = (pick_idx == ID_W'(NREQ-1)) ? '0
                 : pick_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (grant) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !grant) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        sum_q <= sum;
        id_q  <= pick_idx;
        ptr_q <= ptr_nxt;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

`ifdef LFA_ARB_STATS_EN
  logic [15:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || stat_clr) begin
        cnt_q[i] <= '0;
      end else if (req_ready[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_grants[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_lfa16_rr_arbiter.sv
// Directed self-checking bench for lfa16_rr_arbiter (NREQ=4).
// Inputs change #1 after posedge; outputs sampled #2 after posedge.
module tb_lfa16_rr_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       a_v [NREQ];
  logic [15:0]       b_v [NREQ];
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [16:0]       rsp_sum;
  logic [ID_W-1:0]   rsp_id;
`ifdef LFA_ARB_STATS_EN
  logic              stat_clr;
  logic [16*NREQ-1:0] stat_grants;
`endif

  int npass = 0;
  int ntot  = 0;

  // Hand-computed sums of the standard payload below.
  logic [16:0] exp_std [NREQ];

  assign req_a = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign req_b = {b_v[3], b_v[2], b_v[1], b_v[0]};

  always #5 clk = ~clk;

  lfa16_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
`ifdef LFA_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_std();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 16'(16'h0100 * (i + 1));
      b_v[i] = 16'(16'h0011 * (i + 1));
    end
  endtask

  initial begin
    exp_std[0] = 17'h00111;
    exp_std[1] = 17'h00222;
    exp_std[2] = 17'h00333;
    exp_std[3] = 17'h00444;
    set_std();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
`ifdef LFA_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset held 3 cycles with every requester valid.
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
    end
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_sum", 32'(rsp_sum), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);

    // Release: continuous round-robin 0,1,2,3,0,1.
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      #1;
      chk("rr_valid", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_sum", 32'(rsp_sum), 32'(exp_std[k % 4]));
    end

    // Drain: no requests, consumer ready -> EMPTY.
    req_valid = 4'h0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    tick();
    #1;
    chk("drain_valid", 32'(rsp_valid), 32'h0);

    // Single requester 2 (pointer is 2).
    a_v[2]    = 16'h1234;
    b_v[2]    = 16'h0F0F;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'h0;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_sum", 32'(rsp_sum), 32'h02143);
    chk("single_id", 32'(rsp_id), 32'h2);

    // Carry out: pointer 3 scans 3,0,1 -> req 1 wins.
    a_v[1]    = 16'hFFFF;
    b_v[1]    = 16'h0001;
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'h2);
    tick();
    a_v[3]    = 16'hFFFF;
    b_v[3]    = 16'hFFFF;
    req_valid = 4'b1000;
    #1;
    chk("wrap_sum", 32'(rsp_sum), 32'h10000);
    chk("wrap_id", 32'(rsp_id), 32'h1);
    chk("max_ready", 32'(req_ready), 32'h8);
    tick();
    #1;
    chk("max_sum", 32'(rsp_sum), 32'h1FFFE);
    chk("max_id", 32'(rsp_id), 32'h3);

    // Backpressure while FULL (pointer 0).
    set_std();
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      tick();
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_sum", 32'(rsp_sum), 32'h1FFFE);
      chk("bp_id", 32'(rsp_id), 32'h3);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'h1);
    tick();
    #1;
    chk("bp_rel_sum", 32'(rsp_sum), 32'(exp_std[0]));
    chk("bp_rel_id", 32'(rsp_id), 32'h0);

    // Reset mid-operation (FULL, pointer 1) drops result and pointer.
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_sum", 32'(rsp_sum), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ptr", 32'(req_ready), 32'h1);

`ifdef LFA_ARB_STATS_EN
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 70000; k++) tick();
    req_valid = 4'h0;
    #1;
    chk("stat_sat", 32'(stat_grants[31:16]), 32'hFFFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stat_clr", 32'(stat_grants), 32'h0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
